// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Byte-serial bridge between a 32-bit memory pipeline stage and an 8-bit
//   synchronous SRAM. A request accepted in IDLE walks the four byte lanes
//   (big-endian order), one SRAM cycle per enabled lane. A flush cycle then
//   collects the last read byte, and a DONE cycle presents the final rdata.
//   Latency is the same for every sel/we combination.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ce, we, addr, sel,  request from the memory stage (sampled in IDLE)
//   wdata
//   rdata               assembled read word, held until the next read
//   stall_req           combinational stall while an access is in progress
//   sram_addr, sram_en, byte-wide SRAM port; read data returns one cycle
//   sram_we, sram_wdata after the enable cycle
//   sram_rdata
//
// state  | meaning
// IDLE   | waiting for ce; captures the request
// ACCESS | one SRAM cycle per lane, lane 0..3
// FLUSH  | no SRAM cycle; lane-3 read byte is captured
// DONE   | rdata final, stall released, request ignored
module data_mem_ctrl #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [3:0]        sel,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_we,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        lane, lane_nxt;
  logic [ADDR_W-3:0] cap_addr;
  logic              cap_we;
  logic [3:0]        cap_sel;
  logic [31:0]       cap_wdata;
  logic              rd_pend;
  logic [1:0]        rd_lane;
  logic              lane_active;
  logic [7:0]        lane_wbyte;

  // Only word-aligned bits inside the SRAM range are used.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W], addr[1:0]};

  // Lane k is enabled by sel[3-k].
  assign lane_active = cap_sel[2'd3 - lane];

  always_comb begin
    lane_wbyte = 8'h00;
    case (lane)
      2'd0: lane_wbyte = cap_wdata[31:24];
      2'd1: lane_wbyte = cap_wdata[23:16];
      2'd2: lane_wbyte = cap_wdata[15:8];
      2'd3: lane_wbyte = cap_wdata[7:0];
      default: lane_wbyte = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    lane_nxt   = lane;
    stall_req  = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = 8'h00;
    case (state)
      IDLE: begin
        if (ce) begin
          stall_req = 1'b1;
          state_nxt = ACCESS;
          lane_nxt  = 2'd0;
        end
      end
      ACCESS: begin
        stall_req = 1'b1;
        if (lane_active) begin
          sram_en    = 1'b1;
          sram_we    = cap_we;
          sram_addr  = {cap_addr, lane};
          sram_wdata = cap_we ? lane_wbyte : 8'h00;
        end
        lane_nxt = lane + 2'd1;
        if (lane == 2'd3) state_nxt = FLUSH;
      end
      FLUSH: begin
        stall_req = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences the SRAM port and the stall in the same cycle.
    if (rst) begin
      stall_req  = 1'b0;
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= 2'd0;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_sel   <= 4'h0;
      cap_wdata <= 32'h0;
      rd_pend   <= 1'b0;
      rd_lane   <= 2'd0;
      rdata     <= 32'h0;
    end else begin
      state <= state_nxt;
      lane  <= lane_nxt;
      if (state == IDLE && ce) begin
        cap_addr  <= addr[ADDR_W-1:2];
        cap_we    <= we;
        cap_sel   <= sel;
        cap_wdata <= wdata;
        if (!we) rdata <= 32'h0;
      end
      // A read enable this cycle returns its byte next cycle.
      rd_pend <= (state == ACCESS) && lane_active && !cap_we;
      rd_lane <= lane;
      if (rd_pend) begin
        case (rd_lane)
          2'd0: rdata[31:24] <= sram_rdata;
          2'd1: rdata[23:16] <= sram_rdata;
          2'd2: rdata[15:8]  <= sram_rdata;
          2'd3: rdata[7:0]   <= sram_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic              we;
  logic [31:0]       addr;
  logic [3:0]        sel;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              stall_req;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_we;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0]  smem    [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] ref_rdata;

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .wdata(wdata), .rdata(rdata), .stall_req(stall_req),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM; read port shows noise when no read was issued.
  always @(posedge clk) begin
    if (sram_en === 1'b1 && sram_we === 1'b1)
      smem[sram_addr[11:0]] <= sram_wdata;
    if (sram_en === 1'b1 && sram_we === 1'b0)
      sram_rdata <= smem[sram_addr[11:0]];
    else
      sram_rdata <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [31:0] a, input int k);
    return ADDR_W'(((a & 32'hFFFF_FFFC) + 32'(k)) & ((32'h1 << ADDR_W) - 1));
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input int k);
    return 8'((w >> (24 - 8 * k)) & 32'hFF);
  endfunction

  // Full transaction; entered just after a rising edge, returns just after
  // the edge that ends DONE with ce low.
  task automatic do_txn(input logic t_we, input logic [31:0] t_addr,
                        input logic [3:0] t_sel, input logic [31:0] t_wdata);
    logic [31:0] exp_rd;
    bit          lane_on;
    exp_rd = 32'h0;
    for (int k = 0; k < 4; k++)
      if (t_sel[3-k]) exp_rd |= 32'(ref_mem[lane_addr(t_addr, k)[11:0]]) << (24 - 8 * k);
    ce = 1'b1; we = t_we; addr = t_addr; sel = t_sel; wdata = t_wdata;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", c), 32'(stall_req), 32'(c <= 5));
      lane_on = (c >= 1 && c <= 4) ? t_sel[4-c] : 1'b0;
      chk($sformatf("en_c%0d", c), 32'(sram_en), 32'(lane_on));
      if (lane_on) begin
        chk($sformatf("addr_c%0d", c), 32'(sram_addr), 32'(lane_addr(t_addr, c - 1)));
        chk($sformatf("we_c%0d", c), 32'(sram_we), 32'(t_we));
        if (t_we) chk($sformatf("wdata_c%0d", c), 32'(sram_wdata), 32'(word_byte(t_wdata, c - 1)));
      end else begin
        chk($sformatf("wdata0_c%0d", c), 32'(sram_wdata), 32'h0);
      end
      if (c == 0) chk("rdata_hold_start", rdata, ref_rdata);
      if (c == 6) chk("rdata_done", rdata, t_we ? ref_rdata : exp_rd);
      @(posedge clk); #1;
      if (c < 6) begin
        ce = 1'($urandom); we = 1'($urandom); addr = $urandom;
        sel = 4'($urandom); wdata = $urandom;
      end else begin
        ce = 1'b0;
      end
    end
    if (t_we) begin
      for (int k = 0; k < 4; k++)
        if (t_sel[3-k]) ref_mem[lane_addr(t_addr, k)[11:0]] = word_byte(t_wdata, k);
    end else begin
      ref_rdata = exp_rd;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_stall", 32'(stall_req), 32'h0);
    chk("idle_en", 32'(sram_en), 32'h0);
    chk("idle_rdata_hold", rdata, ref_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rw;
    for (int i = 0; i < 4096; i++) begin
      rw = $urandom;
      smem[i] = rw[7:0];
      ref_mem[i] = rw[7:0];
    end
    ref_rdata = 32'h0;
    rst = 1'b1; ce = 1'b1; we = 1'b1; addr = 32'h104; sel = 4'hF; wdata = 32'h1234_5678;

    // Reset with a live request
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_stall", 32'(stall_req), 32'h0);
      chk("rst_en", 32'(sram_en), 32'h0);
      chk("rst_we", 32'(sram_we), 32'h0);
      chk("rst_wdata", 32'(sram_wdata), 32'h0);
      chk("rst_addr", 32'(sram_addr), 32'h0);
    end
    @(posedge clk); #1;
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0; ce = 1'b0;
    idle_cycle();

    // Directed scenarios
    do_txn(1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF);
    do_txn(1'b0, 32'h100, 4'b1111, 32'h0);
    chk("word_read_value", ref_rdata, 32'hDEAD_BEEF);
    do_txn(1'b1, 32'h101, 4'b0100, 32'h5A5A_5A5A);
    idle_cycle();
    do_txn(1'b0, 32'h100, 4'b1111, 32'h0);
    chk("byte_write_merge", ref_rdata, 32'hDE5A_BEEF);
    do_txn(1'b0, 32'h102, 4'b0010, 32'h0);
    chk("byte_read_value", ref_rdata, 32'h0000_BE00);
    do_txn(1'b1, 32'h100, 4'b0000, 32'hFFFF_FFFF);
    do_txn(1'b0, 32'h100, 4'b0000, 32'h0);
    chk("sel0_read_zero", ref_rdata, 32'h0);
    do_txn(1'b0, 32'h100, 4'b1111, 32'h0);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), $urandom, 4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    // Reset during lane-1 of a word write
    do_txn(1'b0, 32'h200, 4'b1111, 32'h0);
    ce = 1'b1; we = 1'b1; addr = 32'h200; sel = 4'hF; wdata = 32'hA1B2_C3D4;
    @(posedge clk); #1;
    ce = 1'b0;
    @(negedge clk);
    chk("mr_lane0_en", 32'(sram_en), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_stall", 32'(stall_req), 32'h0);
    chk("mr_rst_en", 32'(sram_en), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[12'h200] = 8'hA1;
    ref_rdata = 32'h0;
    @(negedge clk);
    chk("mr_after_stall", 32'(stall_req), 32'h0);
    chk("mr_after_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    repeat (4) idle_cycle();
    do_txn(1'b0, 32'h200, 4'b1111, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
